// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle control sequencer for the MIPS32 core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the datapath
// enables and memory strobes, waits on the memory ready signals with a bounded
// timeout, traps on bad opcodes or stalled memory, and counts retired instructions.
module mips_multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             rf_write_en,
  input  logic             is_jmp,
  input  logic             is_beq,
  input  logic             is_bne,
  input  logic             inv_opcode,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [1:0] CAUSE_INV  = 2'b01;
  localparam logic [1:0] CAUSE_IMEM = 2'b10;
  localparam logic [1:0] CAUSE_DMEM = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  // The counter only has to hold TIMEOUT-1. It traps on the cycle that would
  // take it to TIMEOUT.
  localparam int              WCNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  state_t            state, nextState, fetchOrIdle;
  logic [WCNT_W-1:0] waitCnt;
  logic [1:0]        causeNext;
  logic              retire;
  logic              waiting;
  logic              brTaken;

  assign brTaken = (is_beq & alu_zero) | (is_bne & ~alu_zero);
  assign waiting = ((state == S_FETCH) & ~imem_ready) | ((state == S_MEM) & ~dmem_ready);

  // State, trap cause, wait counter and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      trap_cause <= 2'b00;
      waitCnt    <= '0;
      retired    <= '0;
    end else begin
      state      <= nextState;
      trap_cause <= causeNext;
      if (nextState != state) waitCnt <= '0;
      else if (waiting)       waitCnt <= waitCnt + WCNT_W'(1);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Next-state logic. This block also decides the retire pulse and the trap cause.
  always_comb begin
    nextState   = state;
    causeNext   = trap_cause;
    retire      = 1'b0;
    // A stopped run never aborts an instruction. It only blocks the next fetch.
    fetchOrIdle = run ? S_FETCH : S_IDLE;
    case (state)
      S_IDLE:   if (run) nextState = S_FETCH;
      S_FETCH: begin
        if (imem_ready) nextState = S_DECODE;
        else if (waitCnt == WAIT_LAST) begin
          nextState = S_TRAP;
          causeNext = CAUSE_IMEM;
        end
      end
      S_DECODE: begin
        if (inv_opcode) begin
          nextState = S_TRAP;
          causeNext = CAUSE_INV;
        end else if (is_jmp) begin
          retire    = 1'b1;
          nextState = fetchOrIdle;
        end else begin
          nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq | is_bne) begin
          retire    = 1'b1;
          nextState = fetchOrIdle;
        end else if (mem_read | mem_write) begin
          nextState = S_MEM;
        end else if (rf_write_en) begin
          nextState = S_WB;
        end else begin
          retire    = 1'b1;
          nextState = fetchOrIdle;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (mem_read) nextState = S_WB;
          else begin
            retire    = 1'b1;
            nextState = fetchOrIdle;
          end
        end else if (waitCnt == WAIT_LAST) begin
          nextState = S_TRAP;
          causeNext = CAUSE_DMEM;
        end
      end
      S_WB: begin
        retire    = 1'b1;
        nextState = fetchOrIdle;
      end
      S_TRAP:   nextState = S_TRAP;
      default:  nextState = S_IDLE;
    endcase
  end

  // Datapath strobes and status, decoded from the state and the live inputs
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_src   = PC_SEQ;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        if (!inv_opcode && is_jmp) begin
          pc_write = 1'b1;
          pc_src   = PC_JMP;
        end
      end
      S_EXEC: begin
        if ((is_beq | is_bne) && brTaken) begin
          pc_write = 1'b1;
          pc_src   = PC_BR;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write;
      end
      S_WB:    rf_we = 1'b1;
      default: ;
    endcase
  end

  assign busy   = (state != S_IDLE) && (state != S_TRAP);
  assign halted = (state == S_TRAP);

endmodule
